// File: rtl/dvp_pattern_tx.sv
// OV7670-style parallel pixel bus source: QQVGA YUV422 test patterns (box/ramp/stripes/flat).
// Define DVP_FRAME_SCROLL_EN to add a frame counter that scrolls the ramp one column per frame.
module dvp_pattern_tx #(
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 120,
  parameter int H_BLANK     = 32,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 10,
  parameter int V_FRONT     = 4
) (
  input  logic       clk_25,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       pclk,
  output logic       h_ref,
  output logic       v_sync,
  output logic [7:0] data_out,
  output logic       frame_done,
  output logic       busy
);
  localparam int L        = 2*H_ACTIVE + H_BLANK;
  localparam int SW       = $clog2(L);
  localparam int LINE_MAX = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int LW       = $clog2(LINE_MAX);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t          state, nxt_state;
  logic [SW-1:0]   slot, nxt_slot;
  logic [LW-1:0]   line, nxt_line, phase_last;
  logic [1:0]      pat, nxt_pat;
  logic            nxt_pclk, nxt_busy, nxt_frame_done, nxt_h_ref, nxt_v_sync;
  logic [7:0]      nxt_data, x8, y8, yval;
  logic            adv, line_end, phase_end, load, h_act;

`ifdef DVP_FRAME_SCROLL_EN
  logic [7:0] frame_cnt;
  always_ff @(posedge clk_25 or posedge reset)
    if (reset)           frame_cnt <= '0;
    else if (frame_done) frame_cnt <= frame_cnt + 8'd1;
`endif

  always_comb begin
    case (state)
      VSYNC:   phase_last = LW'(VSYNC_LINES - 1);
      VBACK:   phase_last = LW'(V_BACK - 1);
      ACTIVE:  phase_last = LW'(V_ACTIVE - 1);
      default: phase_last = LW'(V_FRONT - 1);
    endcase
  end

  // a new byte slot begins on the edge where pclk falls
  assign adv       = busy && pclk;
  assign line_end  = (slot == SW'(L - 1));
  assign phase_end = line_end && (line == phase_last);

  always_comb begin
    nxt_state      = state;
    nxt_slot       = slot;
    nxt_line       = line;
    nxt_pat        = pat;
    nxt_busy       = busy;
    nxt_pclk       = busy ? ~pclk : 1'b0;
    nxt_frame_done = 1'b0;
    load           = 1'b0;
    if (state == IDLE) begin
      if (enable) begin
        nxt_state = VSYNC;
        nxt_pat   = pattern_sel;
        nxt_busy  = 1'b1;
        nxt_slot  = '0;
        nxt_line  = '0;
        load      = 1'b1;
      end
    end else if (adv) begin
      load = 1'b1;
      if (!line_end) nxt_slot = slot + 1'b1;
      else begin
        nxt_slot = '0;
        nxt_line = line + 1'b1;
        if (phase_end) begin
          nxt_line = '0;
          case (state)
            VSYNC:  nxt_state = VBACK;
            VBACK:  nxt_state = ACTIVE;
            ACTIVE: nxt_state = VFRONT;
            default: begin
              nxt_frame_done = 1'b1;
              if (enable) begin
                nxt_state = VSYNC;
                nxt_pat   = pattern_sel;
              end else begin
                nxt_state = IDLE;
                nxt_busy  = 1'b0;
                nxt_pclk  = 1'b0;
              end
            end
          endcase
        end
      end
    end
  end

  // bus values for the slot being entered
  assign x8    = 8'(nxt_slot >> 1);
  assign y8    = 8'(nxt_line);
  assign h_act = (nxt_state == ACTIVE) && (nxt_slot < SW'(2*H_ACTIVE));

  always_comb begin
    case (nxt_pat)
      2'd0:    yval = (x8 > 8'd40 && x8 < 8'd119 && y8 > 8'd30 && y8 < 8'd89) ? 8'h00 : 8'hFF;
`ifdef DVP_FRAME_SCROLL_EN
      2'd1:    yval = x8 + frame_cnt;
`else
      2'd1:    yval = x8;
`endif
      2'd2:    yval = x8[3] ? 8'hFF : 8'h00;
      default: yval = 8'h80;
    endcase
    nxt_h_ref  = h_act;
    nxt_v_sync = (nxt_state == VSYNC);
    nxt_data   = h_act ? (nxt_slot[0] ? 8'h80 : yval) : 8'h00;
  end

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      slot       <= '0;
      line       <= '0;
      pat        <= '0;
      pclk       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      h_ref      <= 1'b0;
      v_sync     <= 1'b0;
      data_out   <= 8'h00;
    end else begin
      state      <= nxt_state;
      slot       <= nxt_slot;
      line       <= nxt_line;
      pat        <= nxt_pat;
      pclk       <= nxt_pclk;
      busy       <= nxt_busy;
      frame_done <= nxt_frame_done;
      if (load) begin
        h_ref    <= nxt_h_ref;
        v_sync   <= nxt_v_sync;
        data_out <= nxt_data;
      end
    end
  end
endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Bench for dvp_pattern_tx: a bus receiver captures each frame, which is compared
// against pattern rules, a vector table and frame-timing expectations (reduced geometry).
module tb_dvp_pattern_tx;
  localparam int HA = 44, VA = 33, HB = 4, VSL = 2, VB = 1, VF = 1;
  localparam int L = 2*HA + HB;
  localparam int FRAME_CYC = 2*L*(VSL + VB + VA + VF);
`ifdef DVP_FRAME_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic       clk_25 = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic       pclk, h_ref, v_sync, frame_done, busy;
  logic [7:0] data_out;

  dvp_pattern_tx #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
                   .VSYNC_LINES(VSL), .V_BACK(VB), .V_FRONT(VF)) dut (
    .clk_25(clk_25), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .pclk(pclk), .h_ref(h_ref), .v_sync(v_sync), .data_out(data_out),
    .frame_done(frame_done), .busy(busy));

  always #20 clk_25 = ~clk_25;

  typedef struct { int pat; int x; int y; int exp; } vec_t;
  vec_t tbl [15];

  int checks = 0, failures = 0;

  // receiver-side capture of the current frame
  logic [7:0] img [VA][HA];
  int   f_vs_len = 0, f_lines = 0, f_wbad = 0, f_cbad = 0, f_dbad = 0;
  int   vs_run = 0, hr_run = 0, n_vs_rise = 0, n_done = 0;
  logic vs_prev = 1'b0, hr_prev = 1'b0;

  initial forever begin
    @(negedge clk_25);
    if (frame_done) n_done++;
    if (pclk) begin
      if (v_sync && !vs_prev) begin
        n_vs_rise++;
        f_vs_len = 0; f_lines = 0; f_wbad = 0; f_cbad = 0; f_dbad = 0;
        vs_run = 0; hr_prev = 1'b0;
      end
      if (v_sync) vs_run++;
      else if (vs_prev) f_vs_len = vs_run;
      if (h_ref) begin
        if (!hr_prev) begin hr_run = 0; f_lines++; end
        if (hr_run % 2 == 0) begin
          if (f_lines <= VA && hr_run/2 < HA) img[f_lines-1][hr_run/2] = data_out;
        end else if (data_out != 8'h80) f_cbad++;
        hr_run++;
      end else begin
        if (hr_prev && hr_run != 2*HA) f_wbad++;
        if (data_out != 8'h00) f_dbad++;
      end
      vs_prev = v_sync;
      hr_prev = h_ref;
    end
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int scroll_off(int f);
    return SCROLL ? (f % 256) : 0;
  endfunction

  function automatic int exp_y(int pat, int x, int y, int off);
    case (pat)
      0:       return (x > 40 && x < 119 && y > 30 && y < 89) ? 0 : 255;
      1:       return (x + off) % 256;
      2:       return ((x / 8) % 2 == 1) ? 255 : 0;
      default: return 128;
    endcase
  endfunction

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2*FRAME_CYC; i++) begin
      @(negedge clk_25);
      if (frame_done) begin ok = 1'b1; break; end
    end
    check("frame_done_seen", int'(ok), 1);
  endtask

  task automatic wait_lines(int n);
    bit hit = 1'b0;
    for (int i = 0; i < 2*FRAME_CYC; i++) begin
      @(negedge clk_25);
      if (f_lines == n && h_ref) begin hit = 1'b1; break; end
    end
    check($sformatf("reach_line%0d", n), int'(hit), 1);
  endtask

  task automatic check_frame(string tag, int pat, int off);
    int mism = 0, fx = -1, fy = -1;
    check({tag, "_vsync_len"}, f_vs_len, VSL*L);
    check({tag, "_href_pulses"}, f_lines, VA);
    check({tag, "_href_width_bad"}, f_wbad, 0);
    check({tag, "_chroma_bad"}, f_cbad, 0);
    check({tag, "_blank_data_bad"}, f_dbad, 0);
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        if (int'(img[y][x]) != exp_y(pat, x, y, off)) begin
          if (mism == 0) begin fx = x; fy = y; end
          mism++;
        end
    check($sformatf("%s_pixels first_bad(x=%0d,y=%0d)", tag, fx, fy), mism, 0);
    for (int i = 0; i < 15; i++)
      if (tbl[i].pat == pat)
        check($sformatf("%s_vec(x=%0d,y=%0d)", tag, tbl[i].x, tbl[i].y),
              int'(img[tbl[i].y][tbl[i].x]),
              (pat == 1) ? (tbl[i].exp + off) % 256 : tbl[i].exp);
  endtask

  initial begin
    bit ok;
    int bad, d0, v0, fcnt, cur, nxt;
    tbl[0]  = '{0,  0,  0, 8'hFF}; tbl[1]  = '{0, 41, 31, 8'h00};
    tbl[2]  = '{0, 43, 32, 8'h00}; tbl[3]  = '{0, 40, 31, 8'hFF};
    tbl[4]  = '{0, 41, 30, 8'hFF}; tbl[5]  = '{1,  0,  0, 8'h00};
    tbl[6]  = '{1,  1,  0, 8'h01}; tbl[7]  = '{1, 43,  0, 8'h2B};
    tbl[8]  = '{1,  7,  5, 8'h07}; tbl[9]  = '{2,  7,  0, 8'h00};
    tbl[10] = '{2,  8,  0, 8'hFF}; tbl[11] = '{2, 15,  3, 8'hFF};
    tbl[12] = '{2, 16,  3, 8'h00}; tbl[13] = '{3,  0,  0, 8'h80};
    tbl[14] = '{3, 43, 32, 8'h80};

    repeat (5) @(negedge clk_25);
    check("rst_pclk", int'(pclk), 0);
    check("rst_href", int'(h_ref), 0);
    check("rst_vsync", int'(v_sync), 0);
    check("rst_data", int'(data_out), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_busy", int'(busy), 0);

    reset = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk_25);
      if (pclk || h_ref || v_sync || busy || frame_done || data_out != 8'h00) bad++;
    end
    check("idle_quiet", bad, 0);

    // box frame; pattern_sel changes mid-frame and only affects the next one
    fcnt = 0;
    pattern_sel = 2'd0; enable = 1'b1;
    @(negedge clk_25); @(negedge clk_25);
    check("busy_start", int'(busy), 1);
    pattern_sel = 2'd1;
    wait_done(ok);
    check_frame("box", 0, scroll_off(fcnt)); fcnt++;

    wait_lines(3);
    pattern_sel = 2'd2;
    wait_done(ok);
    check_frame("ramp", 1, scroll_off(fcnt)); fcnt++;

    // drop enable mid-frame: frame completes, then the bus goes quiet
    wait_lines(VA/2);
    enable = 1'b0;
    d0 = n_done;
    wait_done(ok);
    check("busy_drop", int'(busy), 0);
    check("pclk_drop", int'(pclk), 0);
    check_frame("stripes", 2, scroll_off(fcnt)); fcnt++;
    v0 = n_vs_rise; bad = 0;
    repeat (4*L) begin
      @(negedge clk_25);
      if (busy || pclk || v_sync || h_ref) bad++;
    end
    check("post_frame_idle", bad, 0);
    check("one_frame_done", n_done - d0, 1);
    check("no_new_vsync", n_vs_rise - v0, 0);

    // reset in the middle of an active line
    pattern_sel = 2'd3; enable = 1'b1;
    wait_lines(VA/2);
    d0 = n_done;
    reset = 1'b1;
    #1;
    check("midrst_href", int'(h_ref), 0);
    check("midrst_vsync", int'(v_sync), 0);
    check("midrst_pclk", int'(pclk), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_data", int'(data_out), 0);
    repeat (3) @(negedge clk_25);
    check("midrst_no_done", n_done - d0, 0);
    fcnt = 0;
    reset = 1'b0;
    wait_lines(2);
    cur = int'($urandom_range(0, 3));
    pattern_sel = 2'(cur);
    wait_done(ok);
    check_frame("flat_restart", 3, scroll_off(fcnt)); fcnt++;

    // randomized back-to-back frames
    for (int r = 0; r < 3; r++) begin
      nxt = int'($urandom_range(0, 3));
      wait_lines(2);
      pattern_sel = 2'(nxt);
      if (r == 2) enable = 1'b0;
      wait_done(ok);
      check_frame($sformatf("rand%0d_p%0d", r, cur), cur, scroll_off(fcnt));
      fcnt++;
      cur = nxt;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
